// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared HDMI/TMDS constants, alignment state enum and counter sizing
package hdmi_pkg;

   localparam int TMDS_WORD_W   = 10;
   localparam int TMDS_DATA_W   = 8;
   localparam int TMDS_XOR_BIT  = 8;
   localparam int TMDS_INV_BIT  = 9;

   localparam logic [TMDS_WORD_W-1:0] TOKEN_C00 = 10'h354;
   localparam logic [TMDS_WORD_W-1:0] TOKEN_C01 = 10'h0AB;
   localparam logic [TMDS_WORD_W-1:0] TOKEN_C10 = 10'h154;
   localparam logic [TMDS_WORD_W-1:0] TOKEN_C11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_SLIP,
      ST_SETTLE,
      ST_LOCKED
   } align_state_t;

   // Bits needed for a counter that runs 0..n-1
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - combinational TMDS word classifier and 10b->8b data decoder
module tmds_word_decode
   import hdmi_pkg::*;
(
   input  logic [TMDS_WORD_W-1:0] word,
   output logic                   is_token,
   output logic [1:0]             ctrl,
   output logic [TMDS_DATA_W-1:0] data
);

   logic [TMDS_DATA_W-1:0] q;

   always_comb begin
      is_token = 1'b1;
      ctrl     = 2'b00;
      case (word)
         TOKEN_C00: ctrl = 2'b00;
         TOKEN_C01: ctrl = 2'b01;
         TOKEN_C10: ctrl = 2'b10;
         TOKEN_C11: ctrl = 2'b11;
         default:   is_token = 1'b0;
      endcase
   end

   assign q = word[TMDS_INV_BIT] ? ~word[TMDS_DATA_W-1:0] : word[TMDS_DATA_W-1:0];

   // Undo the transition-minimising XOR/XNOR chain
   always_comb begin
      data    = '0;
      data[0] = q[0];
      for (int i = 1; i < TMDS_DATA_W; i++) begin
         data[i] = word[TMDS_XOR_BIT] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - one TMDS channel: 2-stage decode pipeline plus word-alignment FSM
module tmds_channel_decoder
   import hdmi_pkg::*;
#(
   parameter int TOKEN_RUN     = 16,
   parameter int SEARCH_WINDOW = 1024,
   parameter int LOSS_WINDOW   = 2048,
   parameter int SLIP_SETTLE   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] raw_i,
   output logic       bitslip_o,
   output logic       aligned_o,
   output logic       de_o,
   output logic [1:0] ctrl_o,
   output logic [7:0] data_o
);

   localparam int RUN_W  = cnt_width(TOKEN_RUN);
   localparam int WIN_W  = cnt_width(SEARCH_WINDOW);
   localparam int LOSS_W = cnt_width(LOSS_WINDOW);
   localparam int SET_W  = cnt_width(SLIP_SETTLE);

   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SLIP_SETTLE - 1);

   logic [9:0]        raw_q;
   logic              tok;
   logic [1:0]        dec_ctrl;
   logic [7:0]        dec_data;
   align_state_t      state;
   logic [RUN_W-1:0]  run_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [LOSS_W-1:0] loss_cnt;
   logic [SET_W-1:0]  settle_cnt;

   tmds_word_decode u_decode (
      .word     (raw_q),
      .is_token (tok),
      .ctrl     (dec_ctrl),
      .data     (dec_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q  <= '0;
         de_o   <= 1'b0;
         ctrl_o <= 2'b00;
         data_o <= 8'h00;
      end else begin
         raw_q <= raw_i;
         de_o  <= ~tok;
         if (tok) ctrl_o <= dec_ctrl;
         else     data_o <= dec_data;
      end
   end

   // Alignment is judged on stage-1 words, in step with the stage-2 decode
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_SEARCH;
         run_cnt    <= '0;
         win_cnt    <= '0;
         loss_cnt   <= '0;
         settle_cnt <= '0;
         bitslip_o  <= 1'b0;
         aligned_o  <= 1'b0;
      end else begin
         bitslip_o <= 1'b0;
         case (state)
            ST_SEARCH: begin
               if (tok && run_cnt == RUN_LAST) begin
                  state     <= ST_LOCKED;
                  aligned_o <= 1'b1;
                  loss_cnt  <= '0;
               end else if (win_cnt == WIN_LAST) begin
                  state     <= ST_SLIP;
                  bitslip_o <= 1'b1;
               end else begin
                  run_cnt <= tok ? run_cnt + 1'b1 : '0;
                  win_cnt <= win_cnt + 1'b1;
               end
            end
            ST_SLIP: begin
               state      <= ST_SETTLE;
               settle_cnt <= '0;
            end
            ST_SETTLE: begin
               if (settle_cnt == SET_LAST) begin
                  state   <= ST_SEARCH;
                  run_cnt <= '0;
                  win_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_LOCKED: begin
               if (tok) begin
                  loss_cnt <= '0;
               end else if (loss_cnt == LOSS_LAST) begin
                  state     <= ST_SEARCH;
                  aligned_o <= 1'b0;
                  run_cnt   <= '0;
                  win_cnt   <= '0;
               end else begin
                  loss_cnt <= loss_cnt + 1'b1;
               end
            end
            default: state <= ST_SEARCH;
         endcase
      end
   end

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter TOKEN_RUN, default 16: consecutive control tokens required to declare word alignment.
REQ-002 SHALL have parameter SEARCH_WINDOW, default 1024: words allowed in SEARCH without a qualifying token run before a bitslip is issued.
REQ-003 SHALL have parameter LOSS_WINDOW, default 2048: words allowed in LOCKED without any control token before alignment is dropped.
REQ-004 SHALL have parameter SLIP_SETTLE, default 4: words ignored after each bitslip.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: pixel clock (25.2 MHz).
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port raw_i, input, 10 bits: deserialized TMDS word; bit 0 is the first bit on the wire.
REQ-009 SHALL have port bitslip_o, output, 1 bit: one-cycle pulse that requests the deserializer to shift its word boundary by one bit.
REQ-010 SHALL have port aligned_o, output, 1 bit: high while in LOCKED.
REQ-011 SHALL have port de_o, output, 1 bit: high when the word is a data period word (not a control token).
REQ-012 SHALL have port ctrl_o, output, 2 bits: decoded C1:C0, held from the last token.
REQ-013 SHALL have port data_o, output, 8 bits: decoded video byte; valid when de_o is high.

Function
REQ-014 SHALL map control tokens as: 0x354 -> ctrl 00; 0x0AB -> 01; 0x154 -> 10; 0x2AB -> 11.
REQ-015 SHALL decode non-token words as: raw[9]=1 inverts raw[7:0] to q; d0=q0; for i=1..7, di = qi^q(i-1) when raw[8]=1 and ~(qi^q(i-1)) when raw[8]=0.
REQ-016 SHALL have a fixed latency of 2 clocks from raw_i to de_o, ctrl_o and data_o: stage 1 registers raw_i; stage 2 registers the classification and decode.
REQ-017 SHALL hold data_o at its previous value while de_o is low, and hold ctrl_o at its previous value while de_o is high.
REQ-018 SHALL implement alignment FSM states SEARCH, SLIP, SETTLE and LOCKED.
REQ-019 SHALL, in SEARCH, increment the run counter on each stage-1 token and clear it on any non-token; the run counter reaching TOKEN_RUN SHALL cause a transition to LOCKED.
REQ-020 SHALL, in SEARCH, count words in a window counter; the window counter reaching SEARCH_WINDOW-1 without a transition to LOCKED SHALL cause a transition to SLIP.
REQ-021 SHALL, in SLIP, assert bitslip_o for exactly 1 cycle, then go to SETTLE.
REQ-022 SHALL, in SETTLE, wait SLIP_SETTLE cycles, then go to SEARCH with the run and window counters cleared.
REQ-023 SHALL, in LOCKED, clear the loss counter on every token; the loss counter reaching LOSS_WINDOW-1 SHALL cause a transition to SEARCH.
REQ-024 SHALL give the run completing on the same cycle as the window expiring priority, so the FSM goes to LOCKED.
REQ-025 SHALL never assert bitslip_o outside SLIP; bitslip requests SHALL be unbounded, since the deserializer wraps after 10 slips.
REQ-026 SHALL still decode data_o and de_o while not aligned; consumers gate on aligned_o.

Reset
REQ-027 SHALL, on rst, force: FSM to SEARCH; all counters to 0; bitslip_o=0; aligned_o=0; de_o=0; ctrl_o=00; data_o=0x00; pipeline registers to 0.
REQ-028 SHALL, on reset mid-slip or mid-lock, abandon the current state on the next edge with no bitslip pulse emitted.

Structure
REQ-029 SHALL place the four token constants, the FSM state enum and counter-width functions in the shared package hdmi_pkg, alongside the TMDS encoder constants.
REQ-030 SHALL use one sub-module, tmds_word_decode: a combinational token/data classifier and decoder instantiated between the pipeline stages.

Verification
REQ-031 SHALL verify: 20x 0x354 after reset -> aligned_o rises after the 16th token plus the pipeline delay; ctrl_o=00, de_o=0.
REQ-032 SHALL verify: raw_i=0x100 while locked -> 2 cycles later de_o=1, data_o=0x00; raw_i=0x2FF -> data_o=0xFE.
REQ-033 SHALL verify: a constant non-token word 0x1F0 for 1024 cycles -> one bitslip_o pulse, then none for SLIP_SETTLE cycles, then a new search window.
REQ-034 SHALL verify: a serial token stream rotated by 3 bits -> exactly 3 bitslip pulses (model rotates) before aligned_o=1.
REQ-035 SHALL verify: in LOCKED, 2048 data words with no token -> aligned_o falls; one token at word 2047 -> aligned_o stays high.
REQ-036 SHALL verify: rst asserted on the cycle of the 15th token -> aligned_o=0, all outputs at reset values, a full 16-token run is needed again.
